// File: rtl/mem_req_ctrl.sv
// Command front-end for a single-port RAM: queues read/write commands, serialises them onto
// the RAM pins and returns read data in order. Define MEM_REQ_CTRL_STATS_EN for wr/rd counters.
module mem_req_ctrl #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_wr_en,
   output logic                  mem_rd_en,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_REQ_CTRL_STATS_EN
   ,
   output logic [15:0]           wr_count,
   output logic [15:0]           rd_count
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} state_t;

   state_t state, next_state;

   logic [FIFO_DEPTH-1:0]                 fifo_wr;
   logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] fifo_addr;
   logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] fifo_wdata;
   logic [PTR_W-1:0]                      wr_ptr, rd_ptr;
   logic [PTR_W:0]                        count;
   logic                                  full, empty, push, pop;

   assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign req_ready = !full && !reset;
   assign push      = req_valid && req_ready;

   // Storage needs no reset; occupancy alone decides what is live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_wr[wr_ptr]    <= req_write;
         fifo_addr[wr_ptr]  <= req_addr;
         fifo_wdata[wr_ptr] <= req_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // A read at the head waits while a response is still pending, keeping responses in order.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               if (fifo_wr[rd_ptr]) begin
                  pop        = 1'b1;
                  next_state = WRITE;
               end else if (!rsp_valid) begin
                  pop        = 1'b1;
                  next_state = READ;
               end
            end
         end
         WRITE:   next_state = IDLE;
         READ:    next_state = CAPTURE;
         CAPTURE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wr_en <= 1'b0;
         mem_rd_en <= 1'b0;
      end else begin
         state     <= next_state;
         mem_wr_en <= (next_state == WRITE);
         mem_rd_en <= (next_state == READ);
         if (pop) mem_addr <= fifo_addr[rd_ptr];
         if (pop && fifo_wr[rd_ptr]) mem_wdata <= fifo_wdata[rd_ptr];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else if (state == CAPTURE) begin
         rsp_valid <= 1'b1;
         rsp_rdata <= mem_rdata;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

`ifdef MEM_REQ_CTRL_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_count <= '0;
         rd_count <= '0;
      end else begin
         if (state == WRITE   && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
         if (state == CAPTURE && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: RAM model, scoreboard on an abstract memory image, directed
// latency/ordering/reset scenarios and a randomized traffic phase.
module tb_mem_req_ctrl;
   localparam int AW = 2;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          req_ready, rsp_valid, mem_wr_en, mem_rd_en;
   logic [DW-1:0] rsp_rdata, mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [AW-1:0] mem_addr;
`ifdef MEM_REQ_CTRL_STATS_EN
   logic [15:0]   wr_count, rd_count;
`endif

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   mem_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_REQ_CTRL_STATS_EN
      , .wr_count(wr_count), .rd_count(rd_count)
`endif
   );

   // Single-port RAM: write on the edge, read data valid the cycle after rd_en is sampled.
   logic [DW-1:0] ram [4];
   always @(posedge clk) begin
      if (mem_wr_en) ram[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= ram[mem_addr];
   end

   // Reference: commands take effect in acceptance order, so a read returns the latest
   // accepted write to its address. Reset drops queued writes, so the image becomes unknown.
   logic [DW-1:0] ref_mem [4];
   bit            ref_known [4];
   int            exp_q [$];
   int            e_val;
   bit            prev_hold = 1'b0;
   logic [DW-1:0] prev_rdata = '0;

   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         foreach (ref_known[i]) ref_known[i] = 1'b0;
         prev_hold = 1'b0;
      end else begin
         vectors++;
         if (mem_wr_en && mem_rd_en) begin
            errors++; $display("FAIL rd_wr_exclusive: wr_en=%b rd_en=%b, required not both 1", mem_wr_en, mem_rd_en);
         end
         if (prev_hold) begin
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== prev_rdata) begin
               errors++; $display("FAIL rsp_hold: valid=%b data=%h, required valid=1 data=%h", rsp_valid, rsp_rdata, prev_rdata);
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               vectors++; errors++; $display("FAIL rsp_unexpected: data=%h, required no response", rsp_rdata);
            end else begin
               e_val = exp_q.pop_front();
               if (e_val >= 0) begin
                  vectors++;
                  if (rsp_rdata !== DW'(e_val)) begin
                     errors++; $display("FAIL rsp_data: got %h, required %h", rsp_rdata, DW'(e_val));
                  end
               end
            end
         end
         if (req_valid && req_ready) begin
            if (req_write) begin
               ref_mem[req_addr]   = req_wdata;
               ref_known[req_addr] = 1'b1;
            end else begin
               exp_q.push_back(ref_known[req_addr] ? int'(ref_mem[req_addr]) : -1);
            end
         end
         prev_hold  = rsp_valid && !rsp_ready;
         prev_rdata = rsp_rdata;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      while (!req_ready && n < 50) begin tick(); n++; end
      if (n >= 50) begin
         vectors++; errors++; $display("FAIL push_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
      end
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int max);
      int n = 0;
      while (!rsp_valid && n < max) begin tick(); n++; end
      vectors++;
      if (!rsp_valid) begin
         errors++; $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
      end
   endtask

   task automatic test_reset();
      tick(); tick();
      #2;
      vectors++;
      if ({req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wr_en, mem_rd_en, mem_wdata} !== '0) begin
         errors++; $display("FAIL reset_outputs: ready=%b rv=%b rd=%h addr=%h we=%b re=%b wd=%h, required all 0",
                            req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wr_en, mem_rd_en, mem_wdata);
      end
      tick();
      reset = 1'b0;
      #1;
      vectors++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL reset_release: ready=%b rsp_valid=%b, required 1/0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_write_read();
      rsp_ready = 1'b1;
      tick();
      req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd2; req_wdata = 8'hA5;
      vectors++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b, required 1", req_ready); end
      tick();                     // E0 accept
      req_valid = 1'b0;
      vectors++;
      if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL wr_e0: wr_en=%b, required 0", mem_wr_en); end
      tick();                     // E1 pop
      vectors++;
      if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 || mem_addr !== 2'd2 || mem_wdata !== 8'hA5) begin
         errors++; $display("FAIL wr_e1: we=%b re=%b addr=%h wd=%h, required 1/0/2/a5", mem_wr_en, mem_rd_en, mem_addr, mem_wdata);
      end
      tick();                     // E2
      vectors++;
      if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL wr_e2: wr_en=%b, required 0", mem_wr_en); end
      req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd2;
      tick();                     // R0 accept
      req_valid = 1'b0;
      vectors++;
      if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL rd_r0: rd_en=%b, required 0", mem_rd_en); end
      tick();                     // R1
      vectors++;
      if (mem_rd_en !== 1'b1 || mem_addr !== 2'd2) begin
         errors++; $display("FAIL rd_r1: rd_en=%b addr=%h, required 1/2", mem_rd_en, mem_addr);
      end
      tick();                     // R2
      vectors++;
      if (mem_rd_en !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL rd_r2: rd_en=%b rsp_valid=%b, required 0/0", mem_rd_en, rsp_valid);
      end
      tick();                     // R3
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
         errors++; $display("FAIL rd_r3: rsp_valid=%b data=%h, required 1/a5", rsp_valid, rsp_rdata);
      end
      tick();                     // R4 handshake done
      vectors++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_r4: rsp_valid=%b, required 0", rsp_valid); end
`ifdef MEM_REQ_CTRL_STATS_EN
      vectors++;
      if (wr_count !== 16'd1 || rd_count !== 16'd1) begin
         errors++; $display("FAIL stats_count: wr=%0d rd=%0d, required 1/1", wr_count, rd_count);
      end
`endif
   endtask

   // A pending response blocks the head read, so later commands pile up behind it.
   task automatic test_fill();
      rsp_ready = 1'b0;
      push_cmd(1'b0, 2'd3, '0);
      wait_rsp(10);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1; tick();
      req_write = 1'b1; req_addr = 2'd0; req_wdata = 8'h11; tick();
      req_addr = 2'd1; req_wdata = 8'h22; tick();
      req_addr = 2'd2; req_wdata = 8'h33; tick();
      req_addr = 2'd3; req_wdata = 8'h44;
      vectors++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL fill_full: req_ready=%b, required 0", req_ready); end
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (req_ready !== 1'b0 || mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++; $display("FAIL fill_stall: ready=%b we=%b re=%b, required 0/0/0", req_ready, mem_wr_en, mem_rd_en);
         end
      end
      rsp_ready = 1'b1;
      tick();                     // response handshake
      rsp_ready = 1'b0;
      vectors++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL fill_before_pop: req_ready=%b, required 0", req_ready); end
      tick();                     // head read popped
      vectors++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL fill_after_pop: req_ready=%b, required 1", req_ready); end
      tick();                     // fifth command accepted
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (15) tick();
   endtask

   task automatic test_two_reads();
      rsp_ready = 1'b0;
      push_cmd(1'b0, 2'd1, '0);
      push_cmd(1'b0, 2'd3, '0);
      wait_rsp(10);
      vectors++;
      if (rsp_rdata !== 8'h22) begin errors++; $display("FAIL two_first: data=%h, required 22", rsp_rdata); end
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h22 || mem_rd_en !== 1'b0) begin
            errors++; $display("FAIL two_hold: valid=%b data=%h rd_en=%b, required 1/22/0", rsp_valid, rsp_rdata, mem_rd_en);
         end
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      wait_rsp(10);
      vectors++;
      if (rsp_rdata !== 8'h44) begin errors++; $display("FAIL two_second: data=%h, required 44", rsp_rdata); end
      rsp_ready = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_hazard();
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd0; req_wdata = 8'h7F; tick();
      req_write = 1'b0; tick();
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      wait_rsp(12);
      vectors++;
      if (rsp_rdata !== 8'h7F) begin errors++; $display("FAIL hazard: data=%h, required 7f", rsp_rdata); end
      rsp_ready = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_reset_mid_read();
      rsp_ready = 1'b0;
      push_cmd(1'b0, 2'd2, '0);
      wait_rsp(10);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd0; tick();
      req_write = 1'b1; req_addr = 2'd1; req_wdata = 8'h55; tick();
      req_addr = 2'd3; req_wdata = 8'h66; tick();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();                     // handshake
      rsp_ready = 1'b0;
      tick();                     // read popped -> READ
      vectors++;
      if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL mid_in_read: rd_en=%b, required 1", mem_rd_en); end
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
         errors++; $display("FAIL mid_reset: re=%b we=%b rv=%b ready=%b, required 0/0/0/0", mem_rd_en, mem_wr_en, rsp_valid, req_ready);
      end
`ifdef MEM_REQ_CTRL_STATS_EN
      vectors++;
      if (wr_count !== 16'd0 || rd_count !== 16'd0) begin
         errors++; $display("FAIL mid_stats: wr=%0d rd=%0d, required 0/0", wr_count, rd_count);
      end
`endif
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL mid_after: re=%b we=%b rv=%b ready=%b, required 0/0/0/1", mem_rd_en, mem_wr_en, rsp_valid, req_ready);
         end
      end
   endtask

   task automatic test_random();
      int n = 0;
      for (int i = 0; i < 500; i++) begin
         req_valid = ($urandom_range(0, 2) != 0);
         req_write = $urandom_range(0, 1);
         req_addr  = AW'($urandom_range(0, 3));
         req_wdata = DW'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin tick(); n++; end
      vectors++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL random_drain: %0d responses outstanding, required 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_fill();
      test_two_reads();
      test_hazard();
      test_reset_mid_read();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end
endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Request front-end sitting directly upstream of the single-port RAM (`memory`).
- Accepts read/write commands over a valid/ready handshake and buffers them in a small command FIFO.
- Serialises commands onto the RAM's clk/reset/addr/wr_en/rd_en/wdata/rdata pins.
- Returns read data in order over a valid/ready response channel.
- Lets the bench and later system blocks issue back-to-back traffic without modelling RAM timing.

Parameters:
- ADDR_WIDTH, 2, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.

Ports:
- clk  input  1  single clock; all flops on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  command present.
- req_ready  output  1  command accepted when req_valid && req_ready.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  command address.
- req_wdata  input  DATA_WIDTH  write data (ignored for reads).
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  consumer takes response when rsp_valid && rsp_ready.
- rsp_rdata  output  DATA_WIDTH  read data.
- mem_addr  output  ADDR_WIDTH  to RAM addr.
- mem_wr_en  output  1  to RAM wr_en.
- mem_rd_en  output  1  to RAM rd_en.
- mem_wdata  output  DATA_WIDTH  to RAM wdata.
- mem_rdata  input  DATA_WIDTH  from RAM rdata; valid the cycle after mem_rd_en is sampled.

Behaviour:
- Reset (async, active-high): FIFO emptied, FSM to IDLE.
  - req_ready=0 while reset is asserted.
  - rsp_valid=0, rsp_rdata=0, mem_addr=0, mem_wr_en=0, mem_rd_en=0, mem_wdata=0.
  - After reset deasserts, req_ready=1.
- Reset mid-operation: in-flight and queued commands discarded; pending response dropped.
- Command FIFO:
  - {write, addr, wdata} entries; req_ready = !full (combinational, gated by reset).
  - Push on the accept edge.
  - Pop only from the FSM in IDLE; no bypass, so an empty FIFO cannot be popped in the same cycle it is written.
  - Push and pop in the same cycle when neither full nor empty: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; an occupancy counter disambiguates full from empty.
- FSM states: IDLE, WRITE, READ, CAPTURE.
  - IDLE: FIFO non-empty and head is a write -> pop, load cmd register, go to WRITE.
  - IDLE: FIFO non-empty, head is a read, and rsp_valid==0 -> pop, go to READ.
  - IDLE: head is a read but rsp_valid==1 -> stay in IDLE (head held, ordering preserved).
  - WRITE: mem_wr_en=1, mem_addr/mem_wdata from cmd register, for exactly one cycle -> IDLE.
  - READ: mem_rd_en=1, mem_addr from cmd register, for one cycle -> CAPTURE.
  - CAPTURE: rsp_rdata<=mem_rdata, rsp_valid<=1 at end of cycle -> IDLE.
- Memory-side outputs are registered and decoded from state.
  - mem_wr_en and mem_rd_en are never high together.
  - Both are 0 in IDLE and CAPTURE.
- Latency, counted from accept edge E0 with FIFO empty and FSM in IDLE:
  - E1: pop.
  - Write: mem_wr_en high between E1 and E2; RAM writes at E2.
  - Read: mem_rd_en high between E1 and E2; rsp_valid rises after E3.
- Response:
  - rsp_valid holds with stable rsp_rdata until rsp_ready.
  - Clears on the handshake edge unless a new CAPTURE completes on that same edge; it cannot, because reads are blocked while rsp_valid==1.
- Throughput: write one per 2 cycles; read one per 3 cycles plus response drain.

Optional Feature:
- Macro MEM_REQ_CTRL_STATS_EN.
- Defined: adds output ports wr_count[15:0] and rd_count[15:0].
  - Increment on each WRITE / CAPTURE state.
  - Saturate at 16'hFFFF.
  - Cleared by reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset asserted mid-cycle (async) -> all outputs 0 immediately; after deassert req_ready=1, rsp_valid=0.
- Write addr=2 data=8'hA5, then read addr=2, rsp_ready=1 -> mem_wr_en one cycle with mem_addr=2, mem_wdata=A5; rsp_valid 3 edges after read accept, rsp_rdata=A5.
- Four writes back-to-back (addr 0..3, data 11,22,33,44) with FSM stalled -> req_ready=0 after the 4th accept; 5th command held until a pop, then accepted.
- Two reads (addr 1, addr 3) with rsp_ready=0 -> first response 22 held stable; second mem_rd_en not issued until first handshake; then 44 returned; order preserved.
- Interleaved write addr=0 data=7F then read addr=0 queued together -> read returns 7F (no read-before-write hazard).
- Reset asserted while in READ state with 2 commands queued -> FIFO empty, no rsp_valid, mem_rd_en=0; with MEM_REQ_CTRL_STATS_EN defined, counters read 0.
